// File: rtl/peripheral_str_fifo.sv
// J1 I/O-mapped string buffer: 2**AW x DW array used as auto-incrementing RAM (MODE=0)
// or circular FIFO (MODE=1), with a hardware clear sweep. STRFIFO_IRQ_EN adds THRESH and irq.
module peripheral_str_fifo #(
  parameter int            DW   = 8,
  parameter int            AW   = 7,
  parameter logic [DW-1:0] FILL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          rd,
  input  logic          wr,
  input  logic [3:0]    addr,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] dat_out,
  output logic          busy
`ifdef STRFIFO_IRQ_EN
  ,
  output logic          irq
`endif
);
  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [3:0] A_DATA_W = 4'h0;
  localparam logic [3:0] A_DATA_R = 4'h2;
  localparam logic [3:0] A_WPTR   = 4'h4;
  localparam logic [3:0] A_RPTR   = 4'h6;
  localparam logic [3:0] A_CTRL   = 4'h8;
  localparam logic [3:0] A_STAT   = 4'hA;
  localparam logic [3:0] A_COUNT  = 4'hC;
  localparam logic [3:0] A_THRESH = 4'hE;

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp, clr_addr;
  logic [AW:0]   count;
  logic          mode, ovf, udf, err;
  logic          wr_acc, rd_acc, clearing, sweep_last;
  logic          full, empty, clr_start, data_we;
  logic [DW-1:0] status;
`ifdef STRFIFO_IRQ_EN
  logic [AW:0]   thresh;
`endif

  // wr wins over rd when both strobes arrive together
  assign wr_acc     = cs & wr;
  assign rd_acc     = cs & rd & ~wr;
  assign clearing   = (state == CLEAR);
  assign busy       = clearing;
  assign sweep_last = clearing & (&clr_addr);
  assign full       = mode & (count == FULL_CNT);
  assign empty      = mode & (count == '0);
  assign clr_start  = wr_acc & (addr == A_CTRL) & ~clearing & dat_in[0];
  assign data_we    = wr_acc & (addr == A_DATA_W) & ~clearing & ~full;
  assign status     = DW'({err, udf, ovf, mode, full, empty, busy});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start)  state_nxt = CLEAR;
      CLEAR:   if (sweep_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)            clr_addr <= '0;
    else if (clr_start) clr_addr <= '0;
    else if (clearing)  clr_addr <= clr_addr + 1'b1;
  end

  // Array has no reset; sweep and data writes are mutually exclusive via clearing
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing)     mem[clr_addr] <= FILL;
      else if (data_we) mem[wp]       <= dat_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      mode    <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      err     <= 1'b0;
      dat_out <= '0;
`ifdef STRFIFO_IRQ_EN
      thresh  <= '0;
`endif
    end else begin
      if (sweep_last) begin
        wp    <= '0;
        rp    <= '0;
        count <= '0;
      end
      if (wr_acc) begin
        case (addr)
          A_DATA_W: begin
            if (clearing)  err <= 1'b1;
            else if (full) ovf <= 1'b1;
            else begin
              wp <= wp + 1'b1;
              if (mode) count <= count + 1'b1;
            end
          end
          A_WPTR: begin
            if (clearing || mode) err <= 1'b1;
            else                  wp  <= dat_in[AW-1:0];
          end
          A_RPTR: begin
            if (clearing || mode) err <= 1'b1;
            else                  rp  <= dat_in[AW-1:0];
          end
          A_CTRL: begin
            if (clearing) err <= 1'b1;
            else if (dat_in[1] != mode) begin
              mode  <= dat_in[1];
              wp    <= '0;
              rp    <= '0;
              count <= '0;
            end
          end
          A_STAT: begin
            if (dat_in[4]) ovf <= 1'b0;
            if (dat_in[5]) udf <= 1'b0;
            if (dat_in[6]) err <= 1'b0;
          end
`ifdef STRFIFO_IRQ_EN
          A_THRESH: thresh <= dat_in[AW:0];
`endif
          default: ;
        endcase
      end else if (rd_acc) begin
        case (addr)
          A_DATA_R: begin
            if (clearing) err <= 1'b1;
            else if (empty) begin
              // underflow returns FILL and leaves rp where it is
              dat_out <= FILL;
              udf     <= 1'b1;
            end else begin
              dat_out <= mem[rp];
              rp      <= rp + 1'b1;
              if (mode) count <= count - 1'b1;
            end
          end
          A_CTRL: begin
            if (clearing) err     <= 1'b1;
            else          dat_out <= DW'({mode, 1'b0});
          end
          A_STAT:  dat_out <= status;
          A_COUNT: dat_out <= DW'(count);
`ifdef STRFIFO_IRQ_EN
          A_THRESH: dat_out <= DW'(thresh);
`endif
          default: dat_out <= '0;
        endcase
      end
    end
  end

`ifdef STRFIFO_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= (mode & (thresh != '0) & (count >= thresh)) | ovf | udf | err;
  end
`endif

endmodule
